// File: rtl/msk_word_serializer.sv
// Masked parallel-to-serial output stage: loads a full d-share masked state in one
// handshake and drains it word by word over a valid/ready stream, shares never combined.
module msk_word_serializer #(
    parameter int d         = 2,
    parameter int WORD_BITS = 32,
    parameter int NWORDS    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NWORDS*WORD_BITS*d-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_BITS*d-1:0]        out_data,
    output logic                          out_last
);
    localparam int SLICE = WORD_BITS * d;
    localparam int TOTAL = NWORDS * SLICE;
    localparam int IW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]       state;
    logic [IW-1:0]    idx;
    logic [TOTAL-1:0] shreg;
    logic             fire_out;
    logic             load;

    always_comb begin
        out_valid = (state == SEND);
        out_last  = (state == SEND) && (idx == LAST_IDX);
        in_ready  = (state == IDLE) || (out_last && out_ready);
        fire_out  = out_valid && out_ready;
        load      = in_valid && in_ready;
        out_data  = shreg[SLICE-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else if (load) begin
            state <= SEND;
            idx   <= '0;
        end else if (fire_out) begin
            if (out_last) begin
                state <= IDLE;
                idx   <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    // Masked storage carries no reset; a load on the final beat overrides the shift.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= in_data;
        end else if (fire_out) begin
            shreg <= {{SLICE{1'b0}}, shreg[TOTAL-1:SLICE]};
        end
    end

endmodule
